// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RISC-V control path.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, JALR_ADR, JUMP, LUI, AUIPC, BRANCH
    } ctrl_state_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
    } imm_src_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;
    localparam logic [1:0] SRCB_ZERO = 2'd3;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_ALU    = 2'd1;
    localparam logic [1:0] RES_IMM    = 2'd2;
    localparam logic [1:0] RES_LOAD   = 2'd3;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7[5] to an ALU operation; immediate forms only honour
// funct7[5] for shifts, since bit 30 is ordinary immediate data otherwise.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_is_rtype,
    output alu_op_e    o_alu_op
);

    always_comb begin
        o_alu_op = ALU_ADD;
        case (i_funct3)
            3'b000:  o_alu_op = (i_is_rtype && i_funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  o_alu_op = ALU_SLL;
            3'b010:  o_alu_op = ALU_SLT;
            3'b011:  o_alu_op = ALU_SLTU;
            3'b100:  o_alu_op = ALU_XOR;
            3'b101:  o_alu_op = i_funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  o_alu_op = ALU_OR;
            default: o_alu_op = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for a multicycle RV32I datapath; the state register is
// exposed on state_o, and reset gates every side-effecting strobe immediately.
module mc_controller
    import riscv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] Instr_i,
    input  logic            Branch_i,
    output logic            PCWrite_o,
    output logic            MemWrite_o,
    output logic            IRWrite_o,
    output logic            RegWrite_o,
    output logic [2:0]      ImmSrc_o,
    output logic [1:0]      ALUSrcA_o,
    output logic [1:0]      ALUSrcB_o,
    output alu_op_e         ALUControl_o,
    output logic [1:0]      ResultSrc_o,
    output logic            B_EN_o,
    output logic            illegal_o,
    output ctrl_state_e     state_o
);

    ctrl_state_e r_state;
    ctrl_state_e w_next;
    alu_op_e     w_dec_op;
    imm_src_e    w_imm_src;
    logic [6:0]  w_opcode;
    logic        w_pc_write, w_mem_write, w_ir_write, w_reg_write;
    logic        w_b_en, w_illegal;
    logic        w_unused;

    assign w_opcode = Instr_i[6:0];
    assign w_unused = ^{Instr_i[31], Instr_i[29:15], Instr_i[11:7]};

    alu_decoder u_alu_decoder (
        .i_funct3   (Instr_i[14:12]),
        .i_funct7_5 (Instr_i[30]),
        .i_is_rtype (r_state == EXECR),
        .o_alu_op   (w_dec_op)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = FETCH;
        w_pc_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_b_en       = 1'b0;
        w_illegal    = 1'b0;
        w_imm_src    = IMM_I;
        ALUSrcA_o    = SRCA_PC;
        ALUSrcB_o    = SRCB_RS2;
        ALUControl_o = ALU_ADD;
        ResultSrc_o  = RES_ALUOUT;
        case (r_state)
            FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
                ALUSrcB_o   = SRCB_FOUR;
                ResultSrc_o = RES_ALU;
                w_next      = DECODE;
            end
            DECODE: begin
                // ALUOut captures the branch/JAL target for later states
                ALUSrcA_o = SRCA_OLDPC;
                ALUSrcB_o = SRCB_IMM;
                w_imm_src = (w_opcode == OP_BRANCH) ? IMM_B : IMM_J;
                case (w_opcode)
                    OP_LOAD, OP_STORE: w_next = MEMADR;
                    OP_R:              w_next = EXECR;
                    OP_I:              w_next = EXECI;
                    OP_JAL:            w_next = JUMP;
                    OP_JALR:           w_next = JALR_ADR;
                    OP_LUI:            w_next = LUI;
                    OP_AUIPC:          w_next = AUIPC;
                    OP_BRANCH:         w_next = BRANCH;
                    default:           w_illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA_o = SRCA_RS1;
                ALUSrcB_o = SRCB_IMM;
                w_imm_src = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
                w_next    = (w_opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD:  w_next = MEMWB;
            MEMWB: begin
                ResultSrc_o = RES_LOAD;
                w_reg_write = 1'b1;
            end
            MEMWRITE: w_mem_write = 1'b1;
            EXECR: begin
                ALUSrcA_o    = SRCA_RS1;
                ALUControl_o = w_dec_op;
                w_next       = ALUWB;
            end
            EXECI: begin
                ALUSrcA_o    = SRCA_RS1;
                ALUSrcB_o    = SRCB_IMM;
                ALUControl_o = w_dec_op;
                w_next       = ALUWB;
            end
            ALUWB:    w_reg_write = 1'b1;
            JALR_ADR: begin
                ALUSrcA_o = SRCA_RS1;
                ALUSrcB_o = SRCB_IMM;
                w_next    = JUMP;
            end
            JUMP: begin
                // PC takes the precomputed target while ALU forms the link value
                w_pc_write = 1'b1;
                ALUSrcA_o  = SRCA_OLDPC;
                ALUSrcB_o  = SRCB_FOUR;
                w_next     = ALUWB;
            end
            LUI: begin
                w_imm_src   = IMM_U;
                ResultSrc_o = RES_IMM;
                w_reg_write = 1'b1;
            end
            AUIPC: begin
                w_imm_src   = IMM_U;
                ALUSrcA_o   = SRCA_OLDPC;
                ALUSrcB_o   = SRCB_IMM;
                ResultSrc_o = RES_ALU;
                w_reg_write = 1'b1;
            end
            BRANCH: begin
                w_b_en     = 1'b1;
                w_pc_write = Branch_i;
            end
            default: w_next = FETCH;
        endcase
    end

    assign PCWrite_o  = w_pc_write  & ~rst_i;
    assign MemWrite_o = w_mem_write & ~rst_i;
    assign IRWrite_o  = w_ir_write  & ~rst_i;
    assign RegWrite_o = w_reg_write & ~rst_i;
    assign B_EN_o     = w_b_en      & ~rst_i;
    assign illegal_o  = w_illegal   & ~rst_i;
    assign ImmSrc_o   = w_imm_src;
    assign state_o    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: every instruction class is walked cycle
// by cycle against hand-written control vectors.
module tb_mc_controller;
    import riscv_pkg::*;

    typedef logic [22:0] vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] Instr_i;
    logic        Branch_i;
    logic        PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o;
    logic [2:0]  ImmSrc_o;
    logic [1:0]  ALUSrcA_o, ALUSrcB_o, ResultSrc_o;
    alu_op_e     ALUControl_o;
    logic        B_EN_o, illegal_o;
    ctrl_state_e state_o;

    int compared   = 0;
    int mismatched = 0;

    mc_controller dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .Instr_i      (Instr_i),
        .Branch_i     (Branch_i),
        .PCWrite_o    (PCWrite_o),
        .MemWrite_o   (MemWrite_o),
        .IRWrite_o    (IRWrite_o),
        .RegWrite_o   (RegWrite_o),
        .ImmSrc_o     (ImmSrc_o),
        .ALUSrcA_o    (ALUSrcA_o),
        .ALUSrcB_o    (ALUSrcB_o),
        .ALUControl_o (ALUControl_o),
        .ResultSrc_o  (ResultSrc_o),
        .B_EN_o       (B_EN_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Register and memory writes must never coincide.
    always @(negedge clk_i) begin
        compared++;
        if (RegWrite_o && MemWrite_o) begin
            mismatched++;
            $display("FAIL excl_write got RegWrite=1 MemWrite=1 required at most one");
        end
    end

    // Field order: state, PCW, MW, IRW, RW, imm, srcA, srcB, alu, result, b_en, illegal
    function automatic vec_t pk(ctrl_state_e s, logic pcw, logic mw, logic irw, logic rw,
                                logic [2:0] imm, logic [1:0] sa, logic [1:0] sb,
                                alu_op_e alu, logic [1:0] rs, logic ben, logic ill);
        return {s, pcw, mw, irw, rw, imm, sa, sb, alu, rs, ben, ill};
    endfunction

    function automatic vec_t obs();
        return {state_o, PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o, ImmSrc_o,
                ALUSrcA_o, ALUSrcB_o, ALUControl_o, ResultSrc_o, B_EN_o, illegal_o};
    endfunction

    function automatic vec_t fetch_v();
        return pk(FETCH, 1, 0, 1, 0, IMM_I, SRCA_PC, SRCB_FOUR, ALU_ADD, RES_ALU, 0, 0);
    endfunction

    function automatic vec_t dec_v(logic [2:0] imm);
        return pk(DECODE, 0, 0, 0, 0, imm, SRCA_OLDPC, SRCB_IMM, ALU_ADD, RES_ALUOUT, 0, 0);
    endfunction

    function automatic vec_t aluwb_v();
        return pk(ALUWB, 0, 0, 0, 1, IMM_I, SRCA_PC, SRCB_RS2, ALU_ADD, RES_ALUOUT, 0, 0);
    endfunction

    task automatic test_reset();
        rst_i    = 1'b1;
        Instr_i  = 32'h0050_0093;
        Branch_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        compared++;
        if (obs() !== pk(FETCH, 0, 0, 0, 0, IMM_I, SRCA_PC, SRCB_FOUR, ALU_ADD, RES_ALU, 0, 0)) begin
            mismatched++;
            $display("FAIL reset_hold got=%h required=%h", obs(),
                     pk(FETCH, 0, 0, 0, 0, IMM_I, SRCA_PC, SRCB_FOUR, ALU_ADD, RES_ALU, 0, 0));
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // addi, srai, addi with imm bit 30 set (must stay ADD), sub
    task automatic test_alu();
        logic [31:0] ins [4];
        vec_t ev [$];
        ins[0] = 32'h0050_0093;
        ins[1] = 32'h4020_D093;
        ins[2] = 32'h4000_0093;
        ins[3] = 32'h4020_81B3;
        for (int k = 0; k < 4; k++) begin
            ev = {};
            ev.push_back(fetch_v());
            ev.push_back(dec_v(IMM_J));
            case (k)
                0: ev.push_back(pk(EXECI, 0, 0, 0, 0, IMM_I, SRCA_RS1, SRCB_IMM, ALU_ADD, RES_ALUOUT, 0, 0));
                1: ev.push_back(pk(EXECI, 0, 0, 0, 0, IMM_I, SRCA_RS1, SRCB_IMM, ALU_SRA, RES_ALUOUT, 0, 0));
                2: ev.push_back(pk(EXECI, 0, 0, 0, 0, IMM_I, SRCA_RS1, SRCB_IMM, ALU_ADD, RES_ALUOUT, 0, 0));
                default: ev.push_back(pk(EXECR, 0, 0, 0, 0, IMM_I, SRCA_RS1, SRCB_RS2, ALU_SUB, RES_ALUOUT, 0, 0));
            endcase
            ev.push_back(aluwb_v());
            Instr_i = ins[k];
            foreach (ev[i]) begin
                #1;
                compared++;
                if (obs() !== ev[i]) begin
                    mismatched++;
                    $display("FAIL alu%0d cyc%0d got=%h required=%h", k, i, obs(), ev[i]);
                end
                @(negedge clk_i);
            end
            compared++;
            if (state_o !== FETCH) begin
                mismatched++;
                $display("FAIL alu%0d_return got=%0d required=%0d", k, state_o, FETCH);
            end
        end
    endtask

    // lw x2,8(x1) then sw x2,4(x1)
    task automatic test_mem();
        vec_t ev [$];
        for (int k = 0; k < 2; k++) begin
            ev = {};
            ev.push_back(fetch_v());
            ev.push_back(dec_v(IMM_J));
            if (k == 0) begin
                Instr_i = 32'h0080_A103;
                ev.push_back(pk(MEMADR, 0, 0, 0, 0, IMM_I, SRCA_RS1, SRCB_IMM, ALU_ADD, RES_ALUOUT, 0, 0));
                ev.push_back(pk(MEMREAD, 0, 0, 0, 0, IMM_I, SRCA_PC, SRCB_RS2, ALU_ADD, RES_ALUOUT, 0, 0));
                ev.push_back(pk(MEMWB, 0, 0, 0, 1, IMM_I, SRCA_PC, SRCB_RS2, ALU_ADD, RES_LOAD, 0, 0));
            end else begin
                Instr_i = 32'h0020_A223;
                ev.push_back(pk(MEMADR, 0, 0, 0, 0, IMM_S, SRCA_RS1, SRCB_IMM, ALU_ADD, RES_ALUOUT, 0, 0));
                ev.push_back(pk(MEMWRITE, 0, 1, 0, 0, IMM_I, SRCA_PC, SRCB_RS2, ALU_ADD, RES_ALUOUT, 0, 0));
            end
            foreach (ev[i]) begin
                #1;
                compared++;
                if (obs() !== ev[i]) begin
                    mismatched++;
                    $display("FAIL mem%0d cyc%0d got=%h required=%h", k, i, obs(), ev[i]);
                end
                @(negedge clk_i);
            end
            compared++;
            if (state_o !== FETCH) begin
                mismatched++;
                $display("FAIL mem%0d_return got=%0d required=%0d", k, state_o, FETCH);
            end
        end
    endtask

    // beq x0,x0,8 with the branch taken and not taken
    task automatic test_branch();
        vec_t ev [$];
        for (int k = 0; k < 2; k++) begin
            Instr_i  = 32'h0000_0463;
            Branch_i = (k == 0);
            ev = {};
            ev.push_back(fetch_v());
            ev.push_back(dec_v(IMM_B));
            ev.push_back(pk(BRANCH, k == 0, 0, 0, 0, IMM_I, SRCA_PC, SRCB_RS2, ALU_ADD, RES_ALUOUT, 1, 0));
            foreach (ev[i]) begin
                #1;
                compared++;
                if (obs() !== ev[i]) begin
                    mismatched++;
                    $display("FAIL branch%0d cyc%0d got=%h required=%h", k, i, obs(), ev[i]);
                end
                @(negedge clk_i);
            end
            compared++;
            if (state_o !== FETCH) begin
                mismatched++;
                $display("FAIL branch%0d_return got=%0d required=%0d", k, state_o, FETCH);
            end
        end
        Branch_i = 1'b0;
    endtask

    // jal x1,16 then jalr x1,0(x2)
    task automatic test_jump();
        vec_t ev [$];
        for (int k = 0; k < 2; k++) begin
            ev = {};
            ev.push_back(fetch_v());
            ev.push_back(dec_v(IMM_J));
            if (k == 0) begin
                Instr_i = 32'h0100_00EF;
            end else begin
                Instr_i = 32'h0001_00E7;
                ev.push_back(pk(JALR_ADR, 0, 0, 0, 0, IMM_I, SRCA_RS1, SRCB_IMM, ALU_ADD, RES_ALUOUT, 0, 0));
            end
            ev.push_back(pk(JUMP, 1, 0, 0, 0, IMM_I, SRCA_OLDPC, SRCB_FOUR, ALU_ADD, RES_ALUOUT, 0, 0));
            ev.push_back(aluwb_v());
            foreach (ev[i]) begin
                #1;
                compared++;
                if (obs() !== ev[i]) begin
                    mismatched++;
                    $display("FAIL jump%0d cyc%0d got=%h required=%h", k, i, obs(), ev[i]);
                end
                @(negedge clk_i);
            end
            compared++;
            if (state_o !== FETCH) begin
                mismatched++;
                $display("FAIL jump%0d_return got=%0d required=%0d", k, state_o, FETCH);
            end
        end
    endtask

    // lui x5,0x12345 then auipc x5,1
    task automatic test_upper();
        vec_t ev [$];
        for (int k = 0; k < 2; k++) begin
            ev = {};
            ev.push_back(fetch_v());
            ev.push_back(dec_v(IMM_J));
            if (k == 0) begin
                Instr_i = 32'h1234_52B7;
                ev.push_back(pk(LUI, 0, 0, 0, 1, IMM_U, SRCA_PC, SRCB_RS2, ALU_ADD, RES_IMM, 0, 0));
            end else begin
                Instr_i = 32'h0000_1297;
                ev.push_back(pk(AUIPC, 0, 0, 0, 1, IMM_U, SRCA_OLDPC, SRCB_IMM, ALU_ADD, RES_ALU, 0, 0));
            end
            foreach (ev[i]) begin
                #1;
                compared++;
                if (obs() !== ev[i]) begin
                    mismatched++;
                    $display("FAIL upper%0d cyc%0d got=%h required=%h", k, i, obs(), ev[i]);
                end
                @(negedge clk_i);
            end
            compared++;
            if (state_o !== FETCH) begin
                mismatched++;
                $display("FAIL upper%0d_return got=%0d required=%0d", k, state_o, FETCH);
            end
        end
    endtask

    // opcodes 0000000 and 1111111 are unsupported
    task automatic test_illegal();
        logic [31:0] ins [2];
        vec_t ev [$];
        ins[0] = 32'h0000_0000;
        ins[1] = 32'h0000_007F;
        for (int k = 0; k < 2; k++) begin
            Instr_i = ins[k];
            ev = {};
            ev.push_back(fetch_v());
            ev.push_back(pk(DECODE, 0, 0, 0, 0, IMM_J, SRCA_OLDPC, SRCB_IMM, ALU_ADD, RES_ALUOUT, 0, 1));
            foreach (ev[i]) begin
                #1;
                compared++;
                if (obs() !== ev[i]) begin
                    mismatched++;
                    $display("FAIL illegal%0d cyc%0d got=%h required=%h", k, i, obs(), ev[i]);
                end
                @(negedge clk_i);
            end
            #1;
            compared++;
            if (state_o !== FETCH || illegal_o !== 1'b0) begin
                mismatched++;
                $display("FAIL illegal%0d_return got state=%0d ill=%b required state=%0d ill=0",
                         k, state_o, illegal_o, FETCH);
            end
        end
    endtask

    // reset raised in MEMWRITE kills the store strobe in that same cycle
    task automatic test_reset_memwrite();
        Instr_i = 32'h0020_A223;
        repeat (3) @(negedge clk_i);
        #1;
        compared++;
        if (state_o !== MEMWRITE || MemWrite_o !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mw_pre got state=%0d mw=%b required state=%0d mw=1",
                     state_o, MemWrite_o, MEMWRITE);
        end
        rst_i = 1'b1;
        #1;
        compared++;
        if (state_o !== MEMWRITE || MemWrite_o !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mw_gate got state=%0d mw=%b required state=%0d mw=0",
                     state_o, MemWrite_o, MEMWRITE);
        end
        @(negedge clk_i);
        #1;
        compared++;
        if (state_o !== FETCH || IRWrite_o !== 1'b0 || PCWrite_o !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mw_next got state=%0d irw=%b pcw=%b required state=%0d irw=0 pcw=0",
                     state_o, IRWrite_o, PCWrite_o, FETCH);
        end
        rst_i = 1'b0;
        #1;
        compared++;
        if (obs() !== fetch_v()) begin
            mismatched++;
            $display("FAIL rst_mw_release got=%h required=%h", obs(), fetch_v());
        end
        @(negedge clk_i);
        #1;
        compared++;
        if (state_o !== DECODE) begin
            mismatched++;
            $display("FAIL rst_mw_resume got=%0d required=%0d", state_o, DECODE);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_jump();
        test_upper();
        test_illegal();
        test_reset_memwrite();
        repeat (2) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
